// File: rtl/core_sequencer_if.sv
// core_sequencer_if: control bundle between the multicycle sequencer and datapath/memory.
// master = sequencer (drives strobes/selects, reads decode fields and flags); slave = datapath side.
interface core_sequencer_if;
   logic [6:0] opcode;
   logic [2:0] f3;
   logic       f7b5;
   logic       zero;
   logic       memReady;
   logic       memReq;
   logic       memWrite;
   logic       memSel;
   logic       irWrite;
   logic       pcWrite;
   logic       regWrite;
   logic [1:0] aluSrcA;
   logic [1:0] aluSrcB;
   logic [2:0] aluControl;
   logic [1:0] resultSrc;
   logic [2:0] state;
   logic       trap;

   modport master (
      input  opcode, f3, f7b5, zero, memReady,
      output memReq, memWrite, memSel, irWrite, pcWrite, regWrite,
      output aluSrcA, aluSrcB, aluControl, resultSrc, state, trap
   );

   modport slave (
      output opcode, f3, f7b5, zero, memReady,
      input  memReq, memWrite, memSel, irWrite, pcWrite, regWrite,
      input  aluSrcA, aluSrcB, aluControl, resultSrc, state, trap
   );
endinterface

// File: rtl/core_sequencer.sv
// core_sequencer: multicycle RV32 control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP).
// Ports: clk, rst (sync, active-high), bus (core_sequencer_if.master: decode fields,
// zero, memReady in; memory/strobe/select controls, state, trap out).
// Option: define SEQ_TIMEOUT_EN to trap after TIMEOUT_CYCLES consecutive memory wait cycles.
module core_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst,
   core_sequencer_if.master bus
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_TRAP      = 3'd7
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [2:0] ALU_SLL = 3'b110;
   localparam logic [2:0] ALU_SRL = 3'b111;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("core_sequencer: TIMEOUT_CYCLES must be 2..255");
   end

   state_t     r_state;
   state_t     w_next;

   logic       w_load;
   logic       w_store;
   logic       w_opimm;
   logic       w_op;
   logic       w_branch;
   logic       w_illegal;
   logic [2:0] w_alu_f3;

   logic       w_memReq;
   logic       w_memWrite;
   logic       w_memSel;
   logic       w_irWrite;
   logic       w_pcWrite;
   logic       w_regWrite;
   logic [1:0] w_aluSrcA;
   logic [1:0] w_aluSrcB;
   logic [2:0] w_aluControl;
   logic [1:0] w_resultSrc;
   logic       w_to_hit;

   assign w_load   = (bus.opcode == OPC_LOAD);
   assign w_store  = (bus.opcode == OPC_STORE);
   assign w_opimm  = (bus.opcode == OPC_OPIMM);
   assign w_op     = (bus.opcode == OPC_OP);
   assign w_branch = (bus.opcode == OPC_BRANCH);

   // Only BEQ/BNE are supported; funct3 011 has no ALU op here.
   assign w_illegal =
      !(w_load | w_store | w_opimm | w_op | w_branch) |
      ((w_op | w_opimm) & (bus.f3 == 3'b011)) |
      (w_branch & (bus.f3[2:1] != 2'b00));

   always_comb begin
      w_alu_f3 = ALU_ADD;
      unique case (bus.f3)
         3'b000:  w_alu_f3 = (w_op & bus.f7b5) ? ALU_SUB : ALU_ADD;
         3'b111:  w_alu_f3 = ALU_AND;
         3'b110:  w_alu_f3 = ALU_OR;
         3'b100:  w_alu_f3 = ALU_XOR;
         3'b010:  w_alu_f3 = ALU_SLT;
         3'b001:  w_alu_f3 = ALU_SLL;
         3'b101:  w_alu_f3 = ALU_SRL;
         default: w_alu_f3 = ALU_ADD;
      endcase
   end

`ifdef SEQ_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_to;

   // The cycle that would be the TIMEOUT_CYCLES-th wait forces TRAP.
   assign w_to_hit = w_memReq & ~bus.memReady & (r_to == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_to <= 8'd0;
      end else if (w_memReq & ~bus.memReady) begin
         r_to <= r_to + 8'd1;
      end else begin
         r_to <= 8'd0;
      end
   end
`else
   assign w_to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_memReq     = 1'b0;
      w_memWrite   = 1'b0;
      w_memSel     = 1'b0;
      w_irWrite    = 1'b0;
      w_pcWrite    = 1'b0;
      w_regWrite   = 1'b0;
      w_aluSrcA    = 2'd0;
      w_aluSrcB    = 2'd0;
      w_aluControl = ALU_ADD;
      w_resultSrc  = 2'd0;
      unique case (r_state)
         S_FETCH: begin
            w_memReq = 1'b1;
            if (bus.memReady) begin
               w_irWrite   = 1'b1;
               w_pcWrite   = 1'b1;
               w_aluSrcB   = 2'd2;
               w_resultSrc = 2'd2;
               w_next      = S_DECODE;
            end
         end
         S_DECODE: begin
            // oldPC + imm: branch target parked in the ALU result register
            w_aluSrcA = 2'd2;
            w_aluSrcB = 2'd1;
            w_next    = w_illegal ? S_TRAP : S_EXECUTE;
         end
         S_EXECUTE: begin
            w_aluSrcA = 2'd1;
            if (w_load | w_store) begin
               w_aluSrcB = 2'd1;
               w_next    = S_MEMORY;
            end else if (w_op | w_opimm) begin
               w_aluSrcB    = w_opimm ? 2'd1 : 2'd0;
               w_aluControl = w_alu_f3;
               w_next       = S_WRITEBACK;
            end else if (w_branch) begin
               w_aluControl = ALU_SUB;
               w_pcWrite    = bus.zero ^ bus.f3[0];
               w_next       = S_FETCH;
            end else begin
               w_next = S_TRAP;
            end
         end
         S_MEMORY: begin
            w_memReq   = 1'b1;
            w_memSel   = 1'b1;
            w_memWrite = w_store;
            if (bus.memReady) begin
               w_next = w_store ? S_FETCH : S_WRITEBACK;
            end
         end
         S_WRITEBACK: begin
            w_regWrite  = 1'b1;
            w_resultSrc = w_load ? 2'd1 : 2'd0;
            w_next      = S_FETCH;
         end
         S_TRAP: begin
            w_next = S_TRAP;
         end
         default: begin
            w_next = S_FETCH;
         end
      endcase
      if (w_to_hit) begin
         w_next = S_TRAP;
      end
   end

   // Reset silences everything but state in the same cycle.
   assign bus.memReq     = w_memReq & ~rst;
   assign bus.memWrite   = w_memWrite & ~rst;
   assign bus.memSel     = w_memSel & ~rst;
   assign bus.irWrite    = w_irWrite & ~rst;
   assign bus.pcWrite    = w_pcWrite & ~rst;
   assign bus.regWrite   = w_regWrite & ~rst;
   assign bus.aluSrcA    = rst ? 2'd0 : w_aluSrcA;
   assign bus.aluSrcB    = rst ? 2'd0 : w_aluSrcB;
   assign bus.aluControl = rst ? 3'd0 : w_aluControl;
   assign bus.resultSrc  = rst ? 2'd0 : w_resultSrc;
   assign bus.state      = r_state;
   assign bus.trap       = (r_state == S_TRAP) & ~rst;

endmodule
